exu_alu_wb_pipe: RTL and testbench
==================================

Name: exu_alu_wb_pipe

Overview:
- Downstream of the ALU control stage. Takes the ALU's per-cycle result (out, destination register, branch-flush info) and stages it through DEPTH pipeline registers to the integer register-file writeback port.
- Provides youngest-first operand forwarding to the decode/issue logic.
- Registers the ALU branch flush (flush_upper, flush_path) for the next-PC logic.
- Honours freeze and lower-pipe flush.

Parameters:
- DEPTH, 3, number of result stages (legal 1..4); writeback comes from stage DEPTH-1.

Ports:
- clk  input  1  top-level clock
- rst_l  input  1  reset; synchronous, active-low
- freeze  input  1  global pipeline hold
- flush_lower  input  1  kill all in-flight stages
- valid_in  input  1  ALU result valid this cycle
- result_in  input  32  ALU out[31:0]
- rd_in  input  5  destination register
- rd_wen_in  input  1  instruction writes rd
- flush_upper_in  input  1  ALU branch flush
- flush_path_in  input  31  ALU flush PC [31:1]
- rs1_addr  input  5  forwarding lookup address 1
- rs2_addr  input  5  forwarding lookup address 2
- fwd_rs1_hit  output  1  rs1 matched a valid stage
- fwd_rs1_data  output  32  forwarded rs1 value
- fwd_rs2_hit  output  1  rs2 matched a valid stage
- fwd_rs2_data  output  32  forwarded rs2 value
- wb_valid  output  1  register-file write strobe
- wb_rd  output  5  writeback address
- wb_data  output  32  writeback data
- flush_upper_ff  output  1  registered branch flush
- flush_path_ff  output  31  registered flush PC [31:1]
- inflight  output  3  count of valid stages

Behaviour:
- Stage registers: valid, rd[4:0], data[31:0] for s0..s(DEPTH-1).
- Reset (rst_l=0 at a clk edge): all stage valids=0, data=0, rd=0, flush_upper_ff=0, flush_path_ff=0. Consequently every output is 0 (wb_valid, wb_rd, wb_data, fwd_*_hit, fwd_*_data, inflight). Reset dominates freeze and flush_lower. Asserting reset mid-stream drops all in-flight results with no writeback.
- Capture (freeze=0, flush_lower=0):
  - s0.valid <= valid_in & rd_wen_in & (rd_in!=0).
  - s0.rd <= rd_in, s0.data <= result_in.
  - s(k).* <= s(k-1).* for k>=1.
- freeze=1, flush_lower=0: all stage registers, flush_upper_ff and flush_path_ff hold.
- flush_lower=1: all stage valids <= 0 next edge, regardless of freeze. Data/rd hold. Same-cycle valid_in is discarded.
- flush_upper_ff <= flush_upper_in & valid_in & ~flush_lower when freeze=0.
  - flush_path_ff loads flush_path_in when flush_upper_in & valid_in & ~freeze.
  - flush_upper_ff self-clears after one unfrozen cycle.
  - The flushing instruction itself is still captured into s0 (a jal result is written back).
- Latency: result presented at unfrozen edge N appears on wb_* after edge N+DEPTH-1, i.e. DEPTH cycles with no freeze. Each frozen cycle adds one.
- wb_valid = s(DEPTH-1).valid & ~freeze & ~flush_lower. wb_rd and wb_data come from s(DEPTH-1), combinationally from flops. Each instruction is written back exactly once.
- Forwarding, per source: hit if some valid stage has rd == addr and addr != 0. The lowest-index (youngest) stage wins. Data is 0 on no hit. Forwarding is purely combinational and unaffected by freeze.
- inflight = population count of stage valids (0..DEPTH).
- rd_in=0 or rd_wen_in=0 gives an invalid bubble: no writeback, no forward, not counted.

Optional Feature:
- Macro RESULT_CLEAR_EN.
- Defined:
  - Whenever a stage's valid is written to 0 (bubble capture or flush_lower), its data and rd are also written to 0.
  - fwd_*_data and wb_data are forced to 0 unless qualified by hit/valid.
  - Purpose: no stale secret-dependent values remain in flops or switch on output wires (masking hygiene).
- Not defined: data/rd of invalid stages hold or shift their previous values; outputs behave as above.

Test Plan:
- Reset, then valid_in=1, rd_in=5, rd_wen_in=1, result_in=0xDEADBEEF with freeze=0 (DEPTH=3) -> wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF exactly 3 cycles later, for one cycle; inflight goes 1,1,1 then 0.
- Back-to-back writes: rd=3 with 0x11 in cycle 0, rd=3 with 0x22 in cycle 1; in cycle 2 rs1_addr=3 -> fwd_rs1_hit=1, fwd_rs1_data=0x22 (youngest wins). rs2_addr=0 -> fwd_rs2_hit=0.
- Capture rd=7, 0xA5A5A5A5, then freeze=1 for 4 cycles -> wb_valid stays 0 while frozen. It pulses once with 0xA5A5A5A5 after freeze drops; total latency is 3+4 cycles.
- Three valid results in flight, pulse flush_lower=1 with freeze=1 -> next cycle inflight=0 and no wb_valid ever issued. With RESULT_CLEAR_EN, all stage data read 0.
- valid_in=1, flush_upper_in=1, flush_path_in=0x4000_0010>>1, rd=1, result=0x104 -> flush_upper_ff=1 for one cycle with flush_path_ff matching; wb of 0x104 to x1 3 cycles later.
- rst_l=0 for one edge while 2 results are in flight -> all outputs 0 next cycle; no writeback afterwards.

Source files
------------

// File: rtl/exu_alu_wb_pipe.sv
// Result writeback pipe: stages ALU results to the integer regfile write port, forwards youngest match, registers branch flush.
// Latency: DEPTH unfrozen cycles from valid_in to wb_valid; forwarding/wb outputs are combinational from stage flops.
// Backpressure: freeze holds every stage (+1 cycle each); flush_lower kills all stages. Build option RESULT_CLEAR_EN zeroes dead data.
module exu_alu_wb_pipe #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        freeze,
  input  logic        flush_lower,
  input  logic        valid_in,
  input  logic [31:0] result_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_wen_in,
  input  logic        flush_upper_in,
  input  logic [30:0] flush_path_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        fwd_rs1_hit,
  output logic [31:0] fwd_rs1_data,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_rs2_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flush_upper_ff,
  output logic [30:0] flush_path_ff,
  output logic [2:0]  inflight
);

`ifdef RESULT_CLEAR_EN
  // Dead stages and unqualified outputs carry zeros, never stale results.
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] dat;
  } stage_t;

  // stg_q[0] is the youngest result, stg_q[DEPTH-1] feeds writeback.
  stage_t stg_q [DEPTH];
  stage_t s0_nxt;

  // Next s0 contents: writes to x0 or non-writing instructions become bubbles.
  always_comb begin
    s0_nxt.vld = valid_in & rd_wen_in & (rd_in != 5'd0);
    s0_nxt.rd  = rd_in;
    s0_nxt.dat = result_in;
    if (ClearEn && !s0_nxt.vld) begin
      s0_nxt.rd  = '0;
      s0_nxt.dat = '0;
    end
  end

  // Stage shift register: reset clears, flush_lower kills valids even when frozen, freeze holds.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= '0;
      end
    end else if (flush_lower) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k].vld <= 1'b0;
        if (ClearEn) begin
          stg_q[k].rd  <= '0;
          stg_q[k].dat <= '0;
        end
      end
    end else if (!freeze) begin
      stg_q[0] <= s0_nxt;
      for (int k = 1; k < DEPTH; k++) begin
        stg_q[k] <= stg_q[k-1];
      end
    end
  end

  // Branch flush register: one-cycle pulse to next-PC logic, path held until the next taken flush.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      flush_upper_ff <= 1'b0;
      flush_path_ff  <= '0;
    end else begin
      if (!freeze) begin
        flush_upper_ff <= flush_upper_in & valid_in & ~flush_lower;
      end
      if (flush_upper_in && valid_in && !freeze) begin
        flush_path_ff <= flush_path_in;
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stg_q[k].vld && (stg_q[k].rd == rs1_addr) && (rs1_addr != 5'd0)) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = stg_q[k].dat;
      end
      if (stg_q[k].vld && (stg_q[k].rd == rs2_addr) && (rs2_addr != 5'd0)) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = stg_q[k].dat;
      end
    end
  end

  // Population count of live stages.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight = inflight + {2'b00, stg_q[k].vld};
    end
  end

  // Writeback from the last stage; a frozen or flushed cycle must not strobe the regfile.
  assign wb_valid = stg_q[DEPTH-1].vld & ~freeze & ~flush_lower;
  assign wb_rd    = stg_q[DEPTH-1].rd;
  assign wb_data  = (ClearEn && !wb_valid) ? 32'd0 : stg_q[DEPTH-1].dat;

endmodule

// File: tb/tb_exu_alu_wb_pipe.sv
// Bench for exu_alu_wb_pipe: directed scenarios then randomized traffic against a queue-based model.
// Latency: expected writebacks are tracked by age in unfrozen edges.
// Backpressure: freeze/flush_lower/reset are randomized alongside the result stream.
module tb_exu_alu_wb_pipe;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        freeze;
  logic        flush_lower;
  logic        valid_in;
  logic [31:0] result_in;
  logic [4:0]  rd_in;
  logic        rd_wen_in;
  logic        flush_upper_in;
  logic [30:0] flush_path_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_data;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush_upper_ff;
  logic [30:0] flush_path_ff;
  logic [2:0]  inflight;

  exu_alu_wb_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush_lower(flush_lower),
    .valid_in(valid_in), .result_in(result_in), .rd_in(rd_in), .rd_wen_in(rd_wen_in),
    .flush_upper_in(flush_upper_in), .flush_path_in(flush_path_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush_upper_ff(flush_upper_ff), .flush_path_ff(flush_path_ff), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Reference model: results in flight, oldest first, with count of unfrozen edges since capture.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
    int          age;
  } ent_t;

  ent_t        pend[$];
  logic        m_fu;
  logic [30:0] m_fp;
  int          tests = 0;
  int          fails = 0;
  bit          started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight result writing addr wins; x0 never forwards.
  function automatic void fwd_model(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].rd == a) begin
          hit = 1'b1;
          d   = pend[i].dat;
          break;
        end
      end
    end
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    if (!rst_l) begin
      pend.delete();
      m_fu = 1'b0;
      m_fp = '0;
    end else begin
      if (!freeze) m_fu = flush_upper_in & valid_in & ~flush_lower;
      if (flush_upper_in && valid_in && !freeze) m_fp = flush_path_in;
      if (flush_lower) begin
        pend.delete();
      end else if (!freeze) begin
        foreach (pend[i]) pend[i].age++;
        if (valid_in && rd_wen_in && rd_in != 5'd0) begin
          ent_t e;
          e.rd  = rd_in;
          e.dat = result_in;
          e.age = 0;
          pend.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic wen, input logic [31:0] res,
                        input logic fz, input logic fl, input logic fu, input logic [30:0] fp);
    valid_in       = v;
    rd_in          = rd;
    rd_wen_in      = wen;
    result_in      = res;
    freeze         = fz;
    flush_lower    = fl;
    flush_upper_in = fu;
    flush_path_in  = fp;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 31'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares every output against the model each cycle, popping on writeback.
  initial begin
    logic        h;
    logic [31:0] d;
    logic        exp_wb;
    wait (started);
    forever begin
      @(negedge clk);
      check("inflight", 32'(inflight), 32'(pend.size()));
      fwd_model(rs1_addr, h, d);
      check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(h));
      check("fwd_rs1_data", fwd_rs1_data, d);
      fwd_model(rs2_addr, h, d);
      check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(h));
      check("fwd_rs2_data", fwd_rs2_data, d);
      check("flush_upper_ff", 32'(flush_upper_ff), 32'(m_fu));
      check("flush_path_ff", 32'(flush_path_ff), 32'(m_fp));
      if (rst_l) begin
        exp_wb = (pend.size() > 0) && (pend[0].age == DEPTH - 1) && !freeze && !flush_lower;
        check("wb_valid", 32'(wb_valid), 32'(exp_wb));
        if (exp_wb) begin
          check("wb_rd", 32'(wb_rd), 32'(pend[0].rd));
          check("wb_data", wb_data, pend[0].dat);
          void'(pend.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst_l    = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    m_fu     = 1'b0;
    m_fp     = '0;
    set_in(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    step();
    started = 1;
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    rst_l = 1'b1;

    // Single result to x5.
    set_in(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 31'd0);
    rs1_addr = 5'd5;
    step();
    idle(4);

    // Back-to-back writes to x3: youngest forwards; rs2=x0 never hits.
    set_in(1'b1, 5'd3, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    set_in(1'b1, 5'd3, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    rs1_addr = 5'd3;
    rs2_addr = 5'd0;
    idle(4);

    // Freeze for four cycles after capture.
    set_in(1'b1, 5'd7, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 31'd0);
    rs1_addr = 5'd7;
    step();
    set_in(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 31'd0);
    for (int i = 0; i < 4; i++) step();
    idle(5);

    // Three in flight, then flush_lower while frozen.
    set_in(1'b1, 5'd1, 1'b1, 32'h101, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    set_in(1'b1, 5'd2, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    set_in(1'b1, 5'd4, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    set_in(1'b1, 5'd6, 1'b1, 32'h606, 1'b1, 1'b1, 1'b0, 31'd0);
    step();
    check("post_flush_inflight", 32'(inflight), 32'd0);
    idle(4);

    // Branch flush with a jal-style writeback to x1.
    set_in(1'b1, 5'd1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 31'h2000_0008);
    rs1_addr = 5'd1;
    step();
    check("jal_flush_path", 32'(flush_path_ff), 32'h2000_0008);
    idle(5);

    // Reset with two results in flight.
    set_in(1'b1, 5'd9, 1'b1, 32'h999, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    set_in(1'b1, 5'd10, 1'b1, 32'hAAA, 1'b0, 1'b0, 1'b0, 31'd0);
    step();
    idle(0);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    check("rst_mid_inflight", 32'(inflight), 32'd0);
    check("rst_mid_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_mid_wb_data", wb_data, 32'd0);
    idle(4);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
             $urandom(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0), 31'($urandom()));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rst_l    = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_l = 1'b1;
    idle(DEPTH + 2);
    check("drain_empty", 32'(pend.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
